// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch-stage bus bundle for instruction memory, prediction buffer, redirect and decode.
interface fetch_unit_if #(parameter int INDEX_BITS = 10);
  logic                  imem_req;
  logic [31:0]           imem_addr;
  logic [31:0]           imem_rdata;
  logic [INDEX_BITS-1:0] bpb_index;
  logic                  bpb_prediction;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic                  dec_valid;
  logic                  dec_ready;
  logic [31:0]           dec_instr;
  logic [31:0]           dec_pc;
  logic                  dec_pred_taken;
  logic [31:0]           dec_pred_target;
  modport master (
    output imem_req, imem_addr, bpb_index, dec_valid, dec_instr, dec_pc, dec_pred_taken, dec_pred_target,
    input  imem_rdata, bpb_prediction, redirect_valid, redirect_pc, dec_ready
  );
  modport slave (
    input  imem_req, imem_addr, bpb_index, dec_valid, dec_instr, dec_pc, dec_pred_taken, dec_pred_target,
    output imem_rdata, bpb_prediction, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC generator with 1-bit branch steering and an in-order fetch queue feeding decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4,
  parameter int          INDEX_BITS  = 10
) (
  input logic         clk,
  input logic         reset,
  fetch_unit_if.master bus
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  logic [31:0]   fetch_pc, resp_pc;
  logic          resp_v, resp_squash;
  logic [31:0]   q_instr  [QUEUE_DEPTH];
  logic [31:0]   q_pc     [QUEUE_DEPTH];
  logic [31:0]   q_target [QUEUE_DEPTH];
  logic          q_taken  [QUEUE_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          issue, push, pop, is_br, is_jal, taken;
  logic [31:0]   instr, b_imm, j_imm, target;
  always_comb begin
    instr  = bus.imem_rdata;
    is_br  = instr[6:0] == 7'b1100011;
    is_jal = instr[6:0] == 7'b1101111;
    b_imm  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    j_imm  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    taken  = is_jal || (is_br && bus.bpb_prediction);
    target = taken ? resp_pc + (is_jal ? j_imm : b_imm) : resp_pc + 32'd4;
    // credit check deliberately ignores a same-cycle pop so every response has a slot
    issue  = !reset && !bus.redirect_valid && (count + CW'(resp_v) < CW'(QUEUE_DEPTH));
    push   = resp_v && !resp_squash && !bus.redirect_valid;
    pop    = bus.dec_valid && bus.dec_ready;
  end
  assign bus.imem_req        = issue;
  assign bus.imem_addr       = fetch_pc;
  assign bus.bpb_index       = resp_pc[INDEX_BITS+1:2];
  assign bus.dec_valid       = !reset && count != '0;
  assign bus.dec_instr       = q_instr[head];
  assign bus.dec_pc          = q_pc[head];
  assign bus.dec_pred_taken  = q_taken[head];
  assign bus.dec_pred_target = q_target[head];
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_v      <= 1'b0;
      resp_squash <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc    <= bus.redirect_pc & ~32'h3;
      resp_v      <= 1'b0;
      resp_squash <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      resp_v <= issue;
      if (issue) begin
        resp_pc     <= fetch_pc;
        resp_squash <= push && taken;
      end
      fetch_pc <= (push && taken) ? target : issue ? fetch_pc + 32'd4 : fetch_pc;
      if (push) begin
        q_instr[tail]  <= instr;
        q_pc[tail]     <= resp_pc;
        q_taken[tail]  <= taken;
        q_target[tail] <= target;
        tail           <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors, corner sequences and a randomized run against a path-walking model.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  fetch_unit_if #(.INDEX_BITS(10)) bus();
  fetch_unit #(.RESET_PC(32'h0), .QUEUE_DEPTH(4), .INDEX_BITS(10)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } entry_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          pred;
    bit          taken;
    logic [31:0] target;
  } vec_t;
  int n_cmp = 0;
  int n_bad = 0;
  int pops = 0;
  logic [31:0] prog [logic [31:0]];
  bit pred_tbl [1024];
  logic [31:0] exp_pc;
  entry_t sb_e;
  function automatic logic [31:0] instr_at(logic [31:0] a);
    return prog.exists(a) ? prog[a] : 32'h0000_0013;
  endfunction
  assign bus.bpb_prediction = pred_tbl[bus.bpb_index];
  always @(posedge clk) bus.imem_rdata <= bus.imem_req ? instr_at(bus.imem_addr) : $urandom;
  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  // Reference: the decode stream is the predicted path walked one instruction at a time.
  function automatic entry_t expect_at(logic [31:0] pc);
    entry_t e;
    logic [31:0] i;
    int off;
    i = instr_at(pc);
    e.instr = i;
    e.pc = pc;
    e.taken = 1'b0;
    e.target = pc + 32'd4;
    if (i[6:0] == 7'b1100011) begin
      off = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
      if (pred_tbl[pc[11:2]]) begin
        e.taken = 1'b1;
        e.target = pc + 32'(off);
      end
    end else if (i[6:0] == 7'b1101111) begin
      off = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
      e.taken = 1'b1;
      e.target = pc + 32'(off);
    end
    return e;
  endfunction
  always @(negedge clk) begin
    if (reset) exp_pc = 32'h0;
    else if (bus.redirect_valid) begin
      check("req_during_redirect", 32'(bus.imem_req), 32'h0);
      exp_pc = bus.redirect_pc & ~32'h3;
    end else if (bus.dec_valid && bus.dec_ready) begin
      sb_e = expect_at(exp_pc);
      check("sb_pc", bus.dec_pc, sb_e.pc);
      check("sb_instr", bus.dec_instr, sb_e.instr);
      check("sb_taken", 32'(bus.dec_pred_taken), 32'(sb_e.taken));
      check("sb_target", bus.dec_pred_target, sb_e.target);
      exp_pc = sb_e.target;
      pops++;
    end
  end
  function automatic logic [31:0] enc_b(logic [12:0] off, logic [2:0] f3);
    return {off[12], off[10:5], 5'd1, 5'd2, f3, off[4:1], off[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] off);
    return {off[20], off[10:1], off[11], off[19:12], 5'd0, 7'b1101111};
  endfunction
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic hold_reset();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask
  task automatic release_reset();
    cyc(2);
    @(negedge clk);
    check("reset_imem_req", 32'(bus.imem_req), 32'h0);
    check("reset_dec_valid", 32'(bus.dec_valid), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask
  task automatic wait_pop(output entry_t got);
    bit ok;
    ok = 1'b0;
    got = '0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (bus.dec_valid && bus.dec_ready && !bus.redirect_valid) begin
        got = '{bus.dec_instr, bus.dec_pc, bus.dec_pred_taken, bus.dec_pred_target};
        ok = 1'b1;
      end
    end
    if (!ok) check("pop_timeout", 32'h0, 32'h1);
  endtask
  vec_t vecs [9];
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    entry_t g;
    int p0;
    vecs[0] = '{32'h0000_0008, 32'h0000_0863, 1'b1, 1'b1, 32'h0000_0018};
    vecs[1] = '{32'h0000_0008, 32'h0000_0863, 1'b0, 1'b0, 32'h0000_000C};
    vecs[2] = '{32'h0000_0020, 32'hFF9F_F06F, 1'b0, 1'b1, 32'h0000_0018};
    vecs[3] = '{32'h0000_0040, 32'hFE00_1EE3, 1'b1, 1'b1, 32'h0000_003C};
    vecs[4] = '{32'h0000_0040, 32'hFE00_1EE3, 1'b0, 1'b0, 32'h0000_0044};
    vecs[5] = '{32'h0000_0100, 32'h0000_8067, 1'b1, 1'b0, 32'h0000_0104};
    vecs[6] = '{32'h0000_0200, 32'h0010_006F, 1'b0, 1'b1, 32'h0000_0A00};
    vecs[7] = '{32'h0000_0300, 32'h0000_0013, 1'b1, 1'b0, 32'h0000_0304};
    vecs[8] = '{32'hFFFF_FFFC, 32'h0000_0013, 1'b0, 1'b0, 32'h0000_0000};
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.dec_ready = 1'b1;
    release_reset();
    // straight-line fetch from reset
    @(negedge clk);
    check("c0_req", 32'(bus.imem_req), 32'h1);
    check("c0_addr", bus.imem_addr, 32'h0);
    check("c0_dec_valid", 32'(bus.dec_valid), 32'h0);
    @(negedge clk);
    check("c1_addr", bus.imem_addr, 32'h4);
    check("c1_dec_valid", 32'(bus.dec_valid), 32'h0);
    @(negedge clk);
    check("c2_dec_valid", 32'(bus.dec_valid), 32'h1);
    check("c2_dec_pc", bus.dec_pc, 32'h0);
    check("c2_target", bus.dec_pred_target, 32'h4);
    check("c2_addr", bus.imem_addr, 32'h8);
    @(negedge clk);
    check("c3_dec_pc", bus.dec_pc, 32'h4);
    // predicted-taken BEQ: one bubble
    hold_reset();
    prog.delete();
    prog[32'h8] = 32'h0000_0863;
    pred_tbl[2] = 1'b1;
    release_reset();
    repeat (4) @(negedge clk);
    check("beq_bpb_index", 32'(bus.bpb_index), 32'h2);
    @(negedge clk);
    check("beq_pc", bus.dec_pc, 32'h8);
    check("beq_taken", 32'(bus.dec_pred_taken), 32'h1);
    check("beq_target", bus.dec_pred_target, 32'h18);
    @(negedge clk);
    check("beq_bubble", 32'(bus.dec_valid), 32'h0);
    @(negedge clk);
    check("beq_next_valid", 32'(bus.dec_valid), 32'h1);
    check("beq_next_pc", bus.dec_pc, 32'h18);
    // same BEQ predicted not taken: no bubble
    hold_reset();
    pred_tbl[2] = 1'b0;
    release_reset();
    repeat (5) @(negedge clk);
    check("beqnt_pc", bus.dec_pc, 32'h8);
    check("beqnt_taken", 32'(bus.dec_pred_taken), 32'h0);
    check("beqnt_target", bus.dec_pred_target, 32'hC);
    @(negedge clk);
    check("beqnt_next_valid", 32'(bus.dec_valid), 32'h1);
    check("beqnt_next_pc", bus.dec_pc, 32'hC);
    // backpressure fills the queue, then drains in order
    hold_reset();
    prog.delete();
    bus.dec_ready = 1'b0;
    release_reset();
    repeat (10) @(negedge clk);
    check("full_req", 32'(bus.imem_req), 32'h0);
    check("full_dec_valid", 32'(bus.dec_valid), 32'h1);
    @(posedge clk);
    #1 bus.dec_ready = 1'b1;
    p0 = pops;
    repeat (20) @(negedge clk);
    check("drain_rate", 32'(pops - p0 >= 19), 32'h1);
    // redirect with three queued and one in flight
    hold_reset();
    bus.dec_ready = 1'b0;
    release_reset();
    cyc(4);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h103;
    bus.dec_ready = 1'b1;
    @(negedge clk);
    check("redir_queue_busy", 32'(bus.dec_valid), 32'h1);
    cyc(1);
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_dec_valid", 32'(bus.dec_valid), 32'h0);
    check("redir_req", 32'(bus.imem_req), 32'h1);
    check("redir_addr", bus.imem_addr, 32'h100);
    wait_pop(g);
    check("redir_first_pc", g.pc, 32'h100);
    // table vectors entered by redirect
    for (int v = 0; v < 9; v++) begin
      @(posedge clk);
      #1;
      prog.delete();
      prog[vecs[v].pc] = vecs[v].instr;
      pred_tbl[vecs[v].pc[11:2]] = vecs[v].pred;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = vecs[v].pc;
      cyc(1);
      bus.redirect_valid = 1'b0;
      wait_pop(g);
      check($sformatf("vec%0d_pc", v), g.pc, vecs[v].pc);
      check($sformatf("vec%0d_instr", v), g.instr, vecs[v].instr);
      check($sformatf("vec%0d_taken", v), 32'(g.taken), 32'(vecs[v].taken));
      check($sformatf("vec%0d_target", v), g.target, vecs[v].target);
      wait_pop(g);
      check($sformatf("vec%0d_next_pc", v), g.pc, vecs[v].target);
    end
    // randomized program, predictions, stalls and redirects
    hold_reset();
    prog.delete();
    for (int a = 0; a < 256; a++) begin
      int r;
      r = int'($urandom % 20);
      if (r < 3) prog[32'(a * 4)] = enc_b(13'((int'($urandom % 64) - 32) * 4), 3'($urandom % 8));
      else if (r < 5) prog[32'(a * 4)] = enc_j(21'((int'($urandom % 128) - 64) * 4));
      else if (r == 5) prog[32'(a * 4)] = 32'h0000_8067;
      else prog[32'(a * 4)] = {12'($urandom), 5'd1, 3'b000, 5'd1, 7'b0010011};
    end
    for (int k = 0; k < 1024; k++) pred_tbl[k] = 1'($urandom);
    release_reset();
    p0 = pops;
    for (int c = 0; c < 3000; c++) begin
      bus.dec_ready = ($urandom % 4) != 0;
      bus.redirect_valid = ($urandom % 50) == 0;
      bus.redirect_pc = $urandom % 4096;
      cyc(1);
    end
    bus.redirect_valid = 1'b0;
    bus.dec_ready = 1'b1;
    check("random_progress", 32'(pops - p0 > 1000), 32'h1);
    cyc(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch-stage PC generator and instruction queue. Drives instruction memory and the branch prediction buffer.
- Predecodes each returned instruction (RV32 encodings). Uses the buffer's 1-bit prediction to steer the next PC for conditional branches.
- Buffers fetch packets in an in-order queue for decode.
- Backend redirects flush all fetch state.

Parameters:
- RESET_PC, 32'h0000_0000, first PC fetched after reset.
- QUEUE_DEPTH, 4, fetch queue entries; must be a power of 2, at least 2.
- INDEX_BITS, 10, width of the prediction buffer index.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- imem_req  output  1  instruction read request this cycle
- imem_addr  output  32  read address; equals fetch_pc
- imem_rdata  input  32  instruction; valid exactly 1 cycle after imem_req
- bpb_index  output  INDEX_BITS  prediction-buffer read index = resp_pc[INDEX_BITS+1:2]
- bpb_prediction  input  1  combinational taken prediction for bpb_index
- redirect_valid  input  1  backend mispredict/exception redirect
- redirect_pc  input  32  redirect target
- dec_valid  output  1  queue head valid
- dec_ready  input  1  decode accepts head
- dec_instr  output  32  head instruction
- dec_pc  output  32  head PC
- dec_pred_taken  output  1  head predicted taken
- dec_pred_target  output  32  head predicted target; pc+4 when not taken

Behaviour:
- State:
  - fetch_pc (32b)
  - in-flight slot: resp_v, resp_pc, resp_squash
  - FIFO of QUEUE_DEPTH entries {instr, pc, taken, target}
  - head/tail pointers and a count of width log2(DEPTH)+1
- Reset:
  - fetch_pc=RESET_PC; resp_v=0, resp_squash=0; queue empty.
  - imem_req=0 and dec_valid=0 during reset and in the cycle it deasserts.
  - The first request is issued in the first cycle with reset low.
- Issue:
  - imem_req = !reset && !redirect_valid && (count + resp_v < QUEUE_DEPTH).
  - The credit check ignores a same-cycle pop. A response therefore always has a free slot.
  - On issue: resp_v<=1, resp_pc<=fetch_pc, resp_squash<=0, fetch_pc<=fetch_pc+4 (mod 2^32). Otherwise resp_v<=0.
- Response (cycle after issue, when resp_v && !resp_squash && !redirect_valid):
  - Conditional branch (opcode 7'b1100011): taken=bpb_prediction; target=resp_pc+sext(B-imm).
  - JAL (opcode 7'b1101111): taken=1; target=resp_pc+sext(J-imm).
  - All other opcodes, including JALR: taken=0; target=resp_pc+4.
  - Push {imem_rdata, resp_pc, taken, taken?target:resp_pc+4}.
  - If taken: fetch_pc<=target, overriding +4. Any request issued this same cycle is wrong-path: resp_squash<=1.
  - A squashed response is dropped and not pushed.
  - Result: exactly a 1-cycle bubble per predicted-taken instruction.
- Pop:
  - On dec_valid && dec_ready.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - dec_* are driven from the registered head entry; no combinational path from imem_rdata.
- Redirect (highest priority):
  - Same cycle: imem_req=0.
  - Next edge: queue cleared (count=0, pointers reset), resp_v<=0, fetch_pc<={redirect_pc[31:2],2'b00}.
  - A pop in the redirect cycle is still accepted by decode; the backend discards it.
  - The first redirected fetch is issued the next cycle.
- Pointers wrap modulo QUEUE_DEPTH.
- Full: no issue while count+resp_v==DEPTH.
- Empty: dec_valid=0; dec_* hold last head contents (don't-care).
- Steady state with dec_ready=1 and no taken predictions: 1 instruction/cycle. First dec_valid 2 cycles after first issue.

Test Plan:
- Reset then run with RESET_PC=0, dec_ready=1, non-branch instrs -> imem_addr 0,4,8,...; dec_pc 0,4,8 consecutively from cycle 2; dec_pred_target=pc+4.
- BEQ with B-imm=+16 at PC 8, bpb_prediction=1 -> bpb_index=2; entry taken=1, target=0x18; fetch at 0xC dropped; next dec_pc=0x18 after 1 bubble.
- Same BEQ with bpb_prediction=0 -> taken=0, target=0xC; no bubble; dec_pc 8 then 0xC.
- JAL imm=-8 at PC 0x20 -> taken=1 regardless of prediction; next fetch 0x18.
- dec_ready=0 for 10 cycles -> count saturates at 4; imem_req low; no entries lost or duplicated. Release -> order preserved.
- redirect_valid with redirect_pc=0x103, queue holding 3 entries and 1 in flight -> next cycle dec_valid=0; in-flight response dropped; following fetch address 0x100.
